// File: rtl/bound_flasher_pkg.sv
// Shared types and constants for the sixteen-lamp bound flasher.
package bound_flasher_pkg;

   localparam int LED_W = 16;
   localparam int CNT_W = 5;

   // Lamp bounds the show bounces between.
   localparam logic [CNT_W-1:0] B_LO  = 5'd0;
   localparam logic [CNT_W-1:0] B_MID = 5'd5;
   localparam logic [CNT_W-1:0] B_HI  = 5'd10;
   localparam logic [CNT_W-1:0] B_MAX = 5'd15;

   // Lit-lamp counts: kickback points (lamp[5] / lamp[10] lit) and all lamps lit.
   localparam logic [CNT_W-1:0] KICK_LO = B_MID + 5'd1;
   localparam logic [CNT_W-1:0] KICK_HI = B_HI + 5'd1;
   localparam logic [CNT_W-1:0] N_FULL  = B_MAX + 5'd1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ON_5    = 3'd1,
      ST_OFF_0   = 3'd2,
      ST_ON_10   = 3'd3,
      ST_OFF_5   = 3'd4,
      ST_ON_15   = 3'd5,
      ST_OFF_ALL = 3'd6
   } state_t;

endpackage

// File: rtl/bf_thermo_decode.sv
// Maps a lit-lamp count (0..16) to a thermometer code: lamps 0..n-1 on.
module bf_thermo_decode
   import bound_flasher_pkg::*;
(
   input  logic [CNT_W-1:0] i_n,
   output logic [LED_W-1:0] o_led
);

   // Lamp gi is lit whenever more than gi lamps are counted.
   generate
      for (genvar gi = 0; gi < LED_W; gi++) begin : g_lamp
         assign o_led[gi] = (i_n > CNT_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher controller: FSM plus up/down lamp counter driving a
// registered thermometer-coded LED bank.
module bound_flasher_ctrl
   import bound_flasher_pkg::*;
(
   input  logic             flick,
   input  logic             clk,
   input  logic             rst,
   output logic [LED_W-1:0] led
);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_n;
   logic [CNT_W-1:0]   w_n_next;
   logic [CNT_W-1:0]   w_n_inc;
   logic [CNT_W-1:0]   w_n_dec;
   logic [LED_W-1:0]   r_led;
   logic [LED_W-1:0]   w_led_next;
   logic               w_kick_pt;

   assign w_n_inc   = r_n + 5'd1;
   assign w_n_dec   = r_n - 5'd1;
   assign w_kick_pt = (r_n == KICK_LO) || (r_n == KICK_HI);

   // Next-state and next-count selection; led follows the next count so it
   // changes on the same edge as the count.
   always_comb begin
      w_state_next = r_state;
      w_n_next     = r_n;
      case (r_state)
         ST_IDLE: begin
            w_n_next = B_LO;
            if (flick) begin
               w_n_next     = 5'd1;
               w_state_next = ST_ON_5;
            end
         end
         ST_ON_5: begin
            w_n_next = w_n_inc;
            if (w_n_inc == KICK_LO) w_state_next = ST_OFF_0;
         end
         ST_OFF_0: begin
            w_n_next = w_n_dec;
            if (w_n_dec == B_LO) w_state_next = ST_ON_10;
         end
         ST_ON_10: begin
            // The lamp[10] peak is held in ON_10 so the flick seen while it is
            // displayed can still choose between the two descents.
            if (r_n == KICK_HI) begin
               w_n_next     = w_n_dec;
               w_state_next = flick ? ST_OFF_0 : ST_OFF_5;
            end else if (flick && (r_n == KICK_LO)) begin
               w_n_next     = w_n_dec;
               w_state_next = ST_OFF_0;
            end else begin
               w_n_next = w_n_inc;
            end
         end
         ST_OFF_5: begin
            w_n_next = w_n_dec;
            if (w_n_dec == B_MID) w_state_next = ST_ON_15;
         end
         ST_ON_15: begin
            if (flick && w_kick_pt) begin
               // Kicking back from lamp[5] lands straight on the lower bound,
               // so the ramp restarts without passing through OFF_5.
               w_n_next     = w_n_dec;
               w_state_next = (w_n_dec == B_MID) ? ST_ON_15 : ST_OFF_5;
            end else begin
               w_n_next = w_n_inc;
               if (w_n_inc == N_FULL) w_state_next = ST_OFF_ALL;
            end
         end
         ST_OFF_ALL: begin
            w_n_next = w_n_dec;
            if (w_n_dec == B_LO) w_state_next = ST_IDLE;
         end
         default: begin
            w_n_next     = B_LO;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   bf_thermo_decode u_thermo (
      .i_n   (w_n_next),
      .o_led (w_led_next)
   );

   // State, count and lamp registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_n     <= B_LO;
         r_led   <= '0;
      end else begin
         r_state <= w_state_next;
         r_n     <= w_n_next;
         r_led   <= w_led_next;
      end
   end

   assign led = r_led;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Self-checking bench for bound_flasher_ctrl: a vector table of
// {rst, flick, expected led} built from lamp-count ramps, applied one clock
// each through an expected-value queue.
module tb_bound_flasher_ctrl;

   typedef struct {
      logic        rst;
      logic        flick;
      logic [15:0] exp_led;
      string       tag;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        flick;
   logic [15:0] led;

   vec_t        vecs[$];
   logic [15:0] exp_q[$];
   int          checks;
   int          errors;
   bit          done;

   bound_flasher_ctrl dut (
      .flick (flick),
      .clk   (clk),
      .rst   (rst),
      .led   (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      done = 1'b0;
      #100000;
      if (!done) begin
         errors = errors + 1;
         $display("FAIL timeout: vector run did not finish within wait limit");
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   function automatic logic [15:0] th(input int n);
      logic [16:0] t;
      t = (17'h1 << n) - 17'h1;
      return t[15:0];
   endfunction

   task automatic add(input logic r, input logic f, input int n, input string tag);
      vec_t v;
      v.rst     = r;
      v.flick   = f;
      v.exp_led = th(n);
      v.tag     = tag;
      vecs.push_back(v);
   endtask

   // Count steps from 'from' to 'to' (exclusive of 'from'), flick low.
   task automatic ramp(input int from, input int to, input string tag);
      if (to > from) begin
         for (int n = from + 1; n <= to; n++) add(1'b1, 1'b0, n, tag);
      end else begin
         for (int n = from - 1; n >= to; n--) add(1'b1, 1'b0, n, tag);
      end
   endtask

   task automatic normal_tail_from5(input string tag);
      ramp(5, 16, tag);
      ramp(16, 0, tag);
   endtask

   initial begin
      rst    = 1'b0;
      flick  = 1'b0;
      checks = 0;
      errors = 0;

      // Reset with random flick, then quiet idle.
      add(1'b0, 1'($urandom_range(0, 1)), 0, "reset");
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 0, "idle");

      // Uninterrupted 56-cycle show.
      add(1'b1, 1'b1, 1, "normal");
      ramp(1, 6, "normal");
      ramp(6, 0, "normal");
      ramp(0, 11, "normal");
      ramp(11, 5, "normal");
      normal_tail_from5("normal");
      add(1'b1, 1'b0, 0, "normal_idle");
      add(1'b1, 1'b0, 0, "normal_idle");

      // Kickback in ON_10 at lamp[10], then a clean continuation.
      add(1'b1, 1'b1, 1, "kick10");
      ramp(1, 6, "kick10");
      ramp(6, 0, "kick10");
      ramp(0, 11, "kick10");
      add(1'b1, 1'b1, 10, "kick10_hit");
      ramp(10, 0, "kick10");
      ramp(0, 11, "kick10");
      ramp(11, 5, "kick10");
      normal_tail_from5("kick10");

      // Kickback in ON_15 at lamp[10], then at lamp[5] right after re-entry.
      add(1'b1, 1'b1, 1, "kick15");
      ramp(1, 6, "kick15");
      ramp(6, 0, "kick15");
      ramp(0, 11, "kick15");
      ramp(11, 5, "kick15");
      ramp(5, 11, "kick15");
      add(1'b1, 1'b1, 10, "kick15_hi");
      ramp(10, 5, "kick15");
      add(1'b1, 1'b1, 6, "kick15_n5");
      add(1'b1, 1'b1, 5, "kick15_lo");
      add(1'b1, 1'b1, 6, "kick15_n5");
      add(1'b1, 1'b1, 5, "kick15_lo");
      normal_tail_from5("kick15");

      // Flick at non-kickback points and in ON_5 / OFF states is ignored.
      add(1'b1, 1'b1, 1, "ignore");
      ramp(1, 3, "ignore");
      add(1'b1, 1'b1, 4, "ignore_on5");
      ramp(4, 6, "ignore");
      add(1'b1, 1'b1, 5, "ignore_off0");
      ramp(5, 0, "ignore");
      ramp(0, 8, "ignore");
      add(1'b1, 1'b1, 9, "ignore_00ff");
      ramp(9, 11, "ignore");
      ramp(11, 9, "ignore");
      add(1'b1, 1'b1, 8, "ignore_off5");
      ramp(8, 5, "ignore");
      ramp(5, 16, "ignore");
      add(1'b1, 1'b1, 15, "ignore_offall");
      ramp(15, 0, "ignore");

      // Kickback in ON_10 at lamp[5], then a mid-show reset and restart.
      add(1'b1, 1'b1, 1, "kick10lo");
      ramp(1, 6, "kick10lo");
      ramp(6, 0, "kick10lo");
      ramp(0, 6, "kick10lo");
      add(1'b1, 1'b1, 5, "kick10lo_hit");
      ramp(5, 0, "kick10lo");
      ramp(0, 11, "kick10lo");
      ramp(11, 5, "kick10lo");
      ramp(5, 9, "kick10lo");
      add(1'b0, 1'b0, 0, "midreset");
      add(1'b1, 1'b0, 0, "midreset_idle");
      add(1'b1, 1'b0, 0, "midreset_idle");
      add(1'b1, 1'b1, 1, "restart");
      ramp(1, 6, "restart");
      add(1'b0, 1'b1, 0, "reset_flick");

      // Apply each vector for one clock; check just after the edge.
      for (int i = 0; i < vecs.size(); i++) begin
         logic [15:0] exp_v;
         rst   = vecs[i].rst;
         flick = vecs[i].flick;
         exp_q.push_back(vecs[i].exp_led);
         @(posedge clk);
         #1;
         exp_v  = exp_q.pop_front();
         checks = checks + 1;
         if (led !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s vec %0d: led=%h expected %h", vecs[i].tag, i, led, exp_v);
         end else begin
            $display("vec %0d %s rst=%b flick=%b led=%h", i, vecs[i].tag,
                     vecs[i].rst, vecs[i].flick, led);
         end
      end

      // Reset-state check: reset held with flick high must leave led dark.
      checks = checks + 1;
      if (led !== 16'h0000) begin
         errors = errors + 1;
         $display("FAIL reset_state: led=%h expected 0000", led);
      end else begin
         $display("reset_state rst=%b flick=%b led=%h", rst, flick, led);
      end

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
